// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-side and response signals of the ALU operation sequencer.
// slave is the sequencer; master is the command source, consumer and ALU.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 4,
  parameter int unsigned CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [SEL_W-1:0] cmd_sel;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_chain;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [SEL_W-1:0] alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic [CNT_W-1:0] op_count;

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_chain, alu_out, alu_carry, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_carry, rsp_zero,
           op_count
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_chain, alu_out, alu_carry, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_carry, rsp_zero,
           op_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Clocked front-end for a combinational ALU: registers one command onto the ALU
// inputs, waits a settle time, captures the result and offers it downstream.
module alu_op_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 16
) (
  input logic              clk,
  input logic              reset,
  alu_op_sequencer_if.slave bus
);

  localparam int unsigned SettleEff = (SETTLE < 1) ? 1 : SETTLE;
  localparam int unsigned SetW      = (SettleEff > 1) ? $clog2(SettleEff) : 1;
  localparam logic [SetW-1:0] SettleLoad = SetW'(SettleEff - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [SetW-1:0]  cnt_q, cnt_d;
  logic             cmd_ready;

  assign cmd_ready = (state_q == StIdle) && !reset;

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    op_count_d   = op_count_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready) begin
          alu_a_d   = bus.cmd_chain ? last_q : bus.cmd_a;
          alu_b_d   = bus.cmd_b;
          alu_sel_d = bus.cmd_sel;
          cnt_d     = SettleLoad;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SetW'(1);
        end else begin
          rsp_result_d = bus.alu_out;
          rsp_carry_d  = bus.alu_carry;
          rsp_zero_d   = (bus.alu_out == '0);
          last_d       = bus.alu_out;
          op_count_d   = op_count_q + CNT_W'(1);
          rsp_valid_d  = 1'b1;
          state_d      = StResp;
        end
      end
      StResp: begin
        // Result fields stay put after the handshake; only valid drops.
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      op_count_q   <= '0;
      last_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      op_count_q   <= op_count_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: one sequencer at SETTLE=1/CNT_W=16, one at SETTLE=3/CNT_W=2,
// each driving a behavioural 8-bit ALU.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;
  logic hold_ok;
  logic seen;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(8), .SEL_W(4), .CNT_W(16)) bus0 ();
  alu_op_sequencer_if #(.WIDTH(8), .SEL_W(4), .CNT_W(2))  bus1 ();

  alu_op_sequencer #(.WIDTH(8), .SEL_W(4), .SETTLE(1), .CNT_W(16)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  alu_op_sequencer #(.WIDTH(8), .SEL_W(4), .SETTLE(3), .CNT_W(2)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // Behavioural ALU; carry is always that of A+B.
  function automatic logic [8:0] alu_model(input logic [3:0] sel, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [8:0] sum;
    logic [7:0] r;
    sum = {1'b0, a} + {1'b0, b};
    case (sel)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd8:    r = a & b;
      4'd9:    r = a | b;
      4'd10:   r = a ^ b;
      4'd11:   r = ~(a | b);
      default: r = 8'h00;
    endcase
    return {sum[8], r};
  endfunction

  always_comb {bus0.alu_carry, bus0.alu_out} = alu_model(bus0.alu_sel, bus0.alu_a, bus0.alu_b);
  always_comb {bus1.alu_carry, bus1.alu_out} = alu_model(bus1.alu_sel, bus1.alu_a, bus1.alu_b);

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic v, input logic [3:0] sel,
                       input logic [7:0] a, input logic [7:0] b, input logic chain);
    if (which == 0) begin
      bus0.cmd_valid = v; bus0.cmd_sel = sel; bus0.cmd_a = a; bus0.cmd_b = b;
      bus0.cmd_chain = chain;
    end else begin
      bus1.cmd_valid = v; bus1.cmd_sel = sel; bus1.cmd_a = a; bus1.cmd_b = b;
      bus1.cmd_chain = chain;
    end
  endtask

  function automatic logic ready_of(input int which);
    return (which == 0) ? bus0.cmd_ready : bus1.cmd_ready;
  endfunction

  function automatic logic valid_of(input int which);
    return (which == 0) ? bus0.rsp_valid : bus1.rsp_valid;
  endfunction

  // Latency = cycle index of first rsp_valid, with the handshake cycle as 0.
  task automatic issue(input int which, input logic [3:0] sel, input logic [7:0] a,
                       input logic [7:0] b, input logic chain, output int latency);
    int n;
    drive(which, 1'b1, sel, a, b, chain);
    n = 0;
    while (!ready_of(which) && n < 50) begin
      step();
      n++;
    end
    step();
    drive(which, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    latency = 1;
    while (!valid_of(which) && latency < 50) begin
      step();
      latency++;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    bus0.rsp_ready = 1'b0;
    bus1.rsp_ready = 1'b0;
    step();
    step();
    chk("rst_cmd_ready0", 32'(bus0.cmd_ready), 0);
    chk("rst_cmd_ready1", 32'(bus1.cmd_ready), 0);
    chk("rst_rsp_valid0", 32'(bus0.rsp_valid), 0);
    chk("rst_alu_a0", 32'(bus0.alu_a), 0);
    chk("rst_alu_sel0", 32'(bus0.alu_sel), 0);
    chk("rst_rsp_result0", 32'(bus0.rsp_result), 0);
    chk("rst_op_count0", 32'(bus0.op_count), 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst0", 32'(bus0.cmd_ready), 1);

    // Basic add
    bus0.rsp_ready = 1'b1;
    issue(0, 4'd0, 8'h0A, 8'h02, 1'b0, lat);
    chk("add_latency", 32'(lat), 2);
    chk("add_result", 32'(bus0.rsp_result), 'h0C);
    chk("add_carry", 32'(bus0.rsp_carry), 0);
    chk("add_zero", 32'(bus0.rsp_zero), 0);
    chk("add_count", 32'(bus0.op_count), 1);
    chk("add_alu_a", 32'(bus0.alu_a), 'h0A);
    step();
    chk("add_valid_clr", 32'(bus0.rsp_valid), 0);
    chk("add_result_kept", 32'(bus0.rsp_result), 'h0C);
    chk("add_back_idle", 32'(bus0.cmd_ready), 1);

    // Overflow to zero, then chain that result into an OR
    issue(0, 4'd0, 8'hF6, 8'h0A, 1'b0, lat);
    chk("ovf_result", 32'(bus0.rsp_result), 'h00);
    chk("ovf_carry", 32'(bus0.rsp_carry), 1);
    chk("ovf_zero", 32'(bus0.rsp_zero), 1);
    chk("ovf_count", 32'(bus0.op_count), 2);
    step();
    issue(0, 4'd9, 8'hFF, 8'h55, 1'b1, lat);
    chk("chain_alu_a", 32'(bus0.alu_a), 'h00);
    chk("chain_alu_b", 32'(bus0.alu_b), 'h55);
    chk("chain_alu_sel", 32'(bus0.alu_sel), 9);
    chk("chain_result", 32'(bus0.rsp_result), 'h55);
    chk("chain_carry", 32'(bus0.rsp_carry), 0);
    chk("chain_count", 32'(bus0.op_count), 3);
    step();

    // Backpressure with a second command waiting
    bus0.rsp_ready = 1'b0;
    issue(0, 4'd8, 8'hF0, 8'h3C, 1'b0, lat);
    chk("bp_latency", 32'(lat), 2);
    chk("bp_result", 32'(bus0.rsp_result), 'h30);
    drive(0, 1'b1, 4'd10, 8'h0F, 8'hFF, 1'b0);
    hold_ok = 1'b1;
    repeat (5) begin
      step();
      if (!(bus0.rsp_valid === 1'b1 && bus0.rsp_result === 8'h30 &&
            bus0.cmd_ready === 1'b0 && bus0.alu_a === 8'hF0)) hold_ok = 1'b0;
    end
    chk("bp_hold_stable", 32'(hold_ok), 1);
    bus0.rsp_ready = 1'b1;
    step();
    chk("bp_valid_clr", 32'(bus0.rsp_valid), 0);
    chk("bp_not_yet_taken", 32'(bus0.alu_a), 'hF0);
    chk("bp_ready_idle", 32'(bus0.cmd_ready), 1);
    step();
    chk("bp2_alu_a", 32'(bus0.alu_a), 'h0F);
    chk("bp2_alu_sel", 32'(bus0.alu_sel), 10);
    drive(0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    step();
    chk("bp2_valid", 32'(bus0.rsp_valid), 1);
    chk("bp2_result", 32'(bus0.rsp_result), 'hF0);
    chk("bp2_count", 32'(bus0.op_count), 5);
    step();

    // Reset while the SETTLE=3 sequencer is in WAIT
    bus1.rsp_ready = 1'b1;
    drive(1, 1'b1, 4'd0, 8'h01, 8'h02, 1'b0);
    step();
    drive(1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    chk("mid_alu_b", 32'(bus1.alu_b), 'h02);
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 32'(bus1.rsp_valid), 0);
    chk("mid_rst_count", 32'(bus1.op_count), 0);
    chk("mid_rst_alu_a", 32'(bus1.alu_a), 0);
    chk("mid_rst_alu_b", 32'(bus1.alu_b), 0);
    chk("mid_rst_alu_sel", 32'(bus1.alu_sel), 0);
    chk("mid_rst_ready", 32'(bus1.cmd_ready), 0);
    reset = 1'b0;
    #1;
    chk("mid_ready_after", 32'(bus1.cmd_ready), 1);
    seen = 1'b0;
    repeat (8) begin
      step();
      if (bus1.rsp_valid !== 1'b0) seen = 1'b1;
    end
    chk("mid_no_response", 32'(seen), 0);
    chk("mid_count_still0", 32'(bus1.op_count), 0);

    // SETTLE=3 latency and 2-bit counter wrap
    for (int i = 0; i < 4; i++) begin
      issue(1, 4'd8, 8'hF0, 8'h3C, 1'b0, lat);
      chk($sformatf("wrap%0d_latency", i), 32'(lat), 4);
      chk($sformatf("wrap%0d_result", i), 32'(bus1.rsp_result), 'h30);
      chk($sformatf("wrap%0d_count", i), 32'(bus1.op_count), 32'((i + 1) % 4));
    end
    step();
    chk("wrap_valid_clr", 32'(bus1.rsp_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
